// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero mask and saturation.
// One conversion per BIN_W+1 cycles: accept in IDLE, then BIN_W shift steps.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     lz_mask,
    output logic                  ovf
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int k = 0; k < n; k++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned SAT_LIMIT = pow10(DIGITS);

    logic [0:0]       r_state;
    logic [BIN_W-1:0] r_shift;
    logic [SW-1:0]    r_scratch;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             r_outValid;
    logic [SW-1:0]    r_bcd;
    logic [DIGITS-1:0] r_lz;
    logic             r_ovf;

    logic [SW-1:0]     w_adj;
    logic [SW-1:0]     w_stepScratch;
    logic [BIN_W-1:0]  w_stepShift;
    logic [DIGITS-1:0] w_lz;
    logic              w_sat;

    assign w_sat = (64'(bin_in) >= SAT_LIMIT);

    // One double-dabble step: per-nibble add-3 correction, then shift the binary MSB in.
    always_comb begin
        w_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end else begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4];
            end
        end
        w_stepScratch = {w_adj[SW-2:0], r_shift[BIN_W-1]};
        w_stepShift   = {r_shift[BIN_W-2:0], 1'b0};
    end

    // Digit i is blank only if it and every more significant digit are zero; digit 0 never blanks.
    always_comb begin : lzCalc
        logic zeroAbove;
        zeroAbove = 1'b1;
        w_lz      = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zeroAbove = zeroAbove & (w_stepScratch[4*d +: 4] == 4'd0);
            w_lz[d]   = zeroAbove;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_sat      <= 1'b0;
            r_outValid <= 1'b0;
            r_bcd      <= '0;
            r_lz       <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (in_valid) begin
                    r_shift   <= bin_in;
                    r_scratch <= '0;
                    r_cnt     <= CNT_W'(BIN_W);
                    r_sat     <= w_sat;
                    r_state   <= ST_SHIFT;
                end
            end else begin
                r_scratch <= w_stepScratch;
                r_shift   <= w_stepShift;
                r_cnt     <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_state    <= ST_IDLE;
                    r_outValid <= 1'b1;
                    if (r_sat) begin
                        r_bcd <= {DIGITS{4'h9}};
                        r_lz  <= '0;
                        r_ovf <= 1'b1;
                    end else begin
                        r_bcd <= w_stepScratch;
                        r_lz  <= w_lz;
                        r_ovf <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready  = ~rst & (r_state == ST_IDLE);
    assign out_valid = r_outValid;
    assign bcd_out   = r_bcd;
    assign lz_mask   = r_lz;
    assign ovf       = r_ovf;

endmodule
